// File: rtl/int_ctrl_pkg.sv
// Shared constants for the CP0 interrupt source block: register window
// indices, timer control bit layout and the timer's interrupt line.
`timescale 1ns/1ps
package int_ctrl_pkg;

   localparam logic [2:0] IC_PEND  = 3'd0;
   localparam logic [2:0] IC_MASK  = 3'd1;
   localparam logic [2:0] IC_MODE  = 3'd2;
   localparam logic [2:0] IC_CNT   = 3'd3;
   localparam logic [2:0] IC_CMP   = 3'd4;
   localparam logic [2:0] IC_TCTRL = 3'd5;

   localparam int TCTRL_EN       = 0;
   localparam int TCTRL_PERIODIC = 1;
   localparam int TIMER_IRQ      = 5;

   // Field order matches the TCTRL bit positions above (periodic = bit 1).
   typedef struct packed {
      logic periodic;
      logic en;
   } tctrl_t;

endpackage

// File: rtl/int_ctrl_if.sv
// Data-memory bus slice seen by the interrupt controller register window.
`timescale 1ns/1ps
interface int_ctrl_if;
   // Bus protocol: no valid/ready. A write is one cycle with we=1 and lands
   // on that clock edge; reads are combinational on addr with no side effect.
   logic        we;
   logic [2:0]  addr;
   logic [31:0] data_in;
   logic [31:0] data_out;

   modport master (output we, output addr, output data_in, input data_out);
   modport slave  (input we, input addr, input data_in, output data_out);
endinterface

// File: rtl/int_ctrl_irq_sync_edge.sv
// One peripheral request: 2-flop synchronizer, history flop for edge
// detection, and the pending latch with write-1-to-clear.
`timescale 1ns/1ps
module irq_sync_edge (
   input  logic clk,
   input  logic rst,
   input  logic src_async,
   input  logic edge_mode,
   input  logic clr,
   output logic pend
);

   logic s1_q, s2_q, s3_q, pend_q;
   logic s1_d, s2_d, s3_d, pend_d;
   logic set;

   always_comb begin
      s1_d   = src_async;
      s2_d   = s1_q;
      s3_d   = s2_q;
      set    = edge_mode ? (s2_q & ~s3_q) : s2_q;
      // A new request on the same edge as a clear must not be lost.
      pend_d = set | (pend_q & ~clr);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         s1_q   <= 1'b0;
         s2_q   <= 1'b0;
         s3_q   <= 1'b0;
         pend_q <= 1'b0;
      end else begin
         s1_q   <= s1_d;
         s2_q   <= s2_d;
         s3_q   <= s3_d;
         pend_q <= pend_d;
      end
   end

   assign pend = pend_q;

endmodule

// File: rtl/int_ctrl.sv
// Interrupt source for CP0: five synchronized peripheral requests plus a
// compare timer, masked into the 6-bit int_ vector, with a bus register window.
`timescale 1ns/1ps
module int_ctrl
   import int_ctrl_pkg::*;
#(
   parameter int unsigned PRESCALE   = 1,
   parameter logic [5:0]  RESET_MASK = 6'h3F
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [4:0]       irq_src,
   int_ctrl_if.slave        bus,
   output logic [5:0]       int_,
   output logic [31:0]      timer_cnt
);

   localparam logic [31:0] PS_LAST = 32'(PRESCALE - 1);

   logic [5:0]  mask_q, mask_d;
   logic [4:0]  mode_q, mode_d;
   logic [31:0] cnt_q, cnt_d;
   logic [31:0] cmp_q, cmp_d;
   logic [31:0] presc_q, presc_d;
   tctrl_t      tctrl_q, tctrl_d;
   logic        pend5_q, pend5_d;
   logic [4:0]  pend_src;
   logic [5:0]  pend;

   logic wr_pend, wr_mask, wr_mode, wr_cnt, wr_cmp, wr_tctrl;
   logic tick, match;

   assign wr_pend  = bus.we && (bus.addr == IC_PEND);
   assign wr_mask  = bus.we && (bus.addr == IC_MASK);
   assign wr_mode  = bus.we && (bus.addr == IC_MODE);
   assign wr_cnt   = bus.we && (bus.addr == IC_CNT);
   assign wr_cmp   = bus.we && (bus.addr == IC_CMP);
   assign wr_tctrl = bus.we && (bus.addr == IC_TCTRL);

   for (genvar i = 0; i < 5; i++) begin : g_src
      irq_sync_edge u_sync (
         .clk       (clk),
         .rst       (rst),
         .src_async (irq_src[i]),
         .edge_mode (mode_q[i]),
         .clr       (wr_pend & bus.data_in[i]),
         .pend      (pend_src[i])
      );
   end

   assign tick  = tctrl_q.en && (presc_q == PS_LAST);
   assign match = tick && (cnt_q == cmp_q);

   always_comb begin
      mask_d  = wr_mask ? bus.data_in[5:0] : mask_q;
      mode_d  = wr_mode ? bus.data_in[4:0] : mode_q;
      cmp_d   = wr_cmp  ? bus.data_in      : cmp_q;
      tctrl_d = tctrl_q;
      cnt_d   = cnt_q;
      presc_d = presc_q;

      // A software CNT write overrides the tick and restarts the prescaler.
      if (wr_cnt) begin
         cnt_d   = bus.data_in;
         presc_d = '0;
      end else begin
         if (!tctrl_q.en || tick) presc_d = '0;
         else                     presc_d = presc_q + 32'd1;
         if (match)     cnt_d = '0;
         else if (tick) cnt_d = cnt_q + 32'd1;
      end

      if (wr_tctrl)                        tctrl_d = tctrl_t'(bus.data_in[1:0]);
      else if (match && !tctrl_q.periodic) tctrl_d.en = 1'b0;

      pend5_d = match | (pend5_q & ~((wr_pend & bus.data_in[TIMER_IRQ]) | wr_cmp));
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         mask_q  <= RESET_MASK;
         mode_q  <= '0;
         cnt_q   <= '0;
         cmp_q   <= 32'hFFFF_FFFF;
         presc_q <= '0;
         tctrl_q <= '0;
         pend5_q <= 1'b0;
      end else begin
         mask_q  <= mask_d;
         mode_q  <= mode_d;
         cnt_q   <= cnt_d;
         cmp_q   <= cmp_d;
         presc_q <= presc_d;
         tctrl_q <= tctrl_d;
         pend5_q <= pend5_d;
      end
   end

   assign pend      = {pend5_q, pend_src};
   assign int_      = pend & mask_q;
   assign timer_cnt = cnt_q;

   always_comb begin
      bus.data_out = '0;
      case (bus.addr)
         IC_PEND:  bus.data_out = {26'b0, pend};
         IC_MASK:  bus.data_out = {26'b0, mask_q};
         IC_MODE:  bus.data_out = {27'b0, mode_q};
         IC_CNT:   bus.data_out = cnt_q;
         IC_CMP:   bus.data_out = cmp_q;
         IC_TCTRL: bus.data_out = {30'b0, tctrl_q};
         default:  bus.data_out = '0;
      endcase
   end

endmodule

// File: tb/tb_int_ctrl.sv
// Bench for int_ctrl: hand-computed per-cycle vector table for the directed
// scenarios, then random traffic against a history-based reference model.
`timescale 1ns/1ps
module tb_int_ctrl;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [4:0]  irq_src = '0;
   logic [5:0]  int_;
   logic [31:0] timer_cnt;

   int_ctrl_if bus ();

   int_ctrl dut (
      .clk       (clk),
      .rst       (rst),
      .irq_src   (irq_src),
      .bus       (bus.slave),
      .int_      (int_),
      .timer_cnt (timer_cnt)
   );

   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_bad = 0;

   // ---------------- reference model ----------------
   logic [5:0]  m_pend, m_mask;
   logic [4:0]  m_mode;
   logic [31:0] m_cnt, m_cmp;
   logic        m_en, m_per;
   int unsigned m_ps;
   logic [4:0]  src_hist[3];  // [0]=applied before last edge, [2]=three edges back

   task automatic model_reset();
      m_pend = '0; m_mask = 6'h3F; m_mode = '0; m_cnt = '0; m_cmp = 32'hFFFF_FFFF;
      m_en = 1'b0; m_per = 1'b0; m_ps = 0;
      for (int k = 0; k < 3; k++) src_hist[k] = '0;
   endtask

   task automatic model_step(input logic r, input logic [4:0] irq, input logic w,
                             input logic [2:0] a, input logic [31:0] d);
      logic [4:0] lvl, prev, set;
      logic [5:0] clr;
      logic tick, hit;
      if (r) begin
         model_reset();
         return;
      end
      // A request seen two edges ago is what may latch now (3-cycle latency).
      lvl  = src_hist[1];
      prev = src_hist[2];
      for (int i = 0; i < 5; i++)
         set[i] = m_mode[i] ? (lvl[i] && !prev[i]) : lvl[i];
      tick = m_en && (m_ps == 0);  // PRESCALE=1: every enabled cycle ticks
      hit  = tick && (m_cnt == m_cmp);
      clr  = (w && a == 3'd0) ? d[5:0] : 6'd0;
      if (w && a == 3'd4) clr[5] = 1'b1;
      m_pend[4:0] = set | (m_pend[4:0] & ~clr[4:0]);
      m_pend[5]   = hit | (m_pend[5] & ~clr[5]);
      if (w && a == 3'd3)  begin m_cnt = d; m_ps = 0; end
      else if (hit)        m_cnt = 0;
      else if (tick)       m_cnt = m_cnt + 1;
      if (w && a == 3'd5)  begin m_en = d[0]; m_per = d[1]; end
      else if (hit && !m_per) m_en = 1'b0;
      if (w && a == 3'd1) m_mask = d[5:0];
      if (w && a == 3'd2) m_mode = d[4:0];
      if (w && a == 3'd4) m_cmp = d;
      src_hist[2] = src_hist[1];
      src_hist[1] = src_hist[0];
      src_hist[0] = irq;
   endtask

   function automatic logic [31:0] model_read(input logic [2:0] a);
      case (a)
         3'd0: return {26'b0, m_pend};
         3'd1: return {26'b0, m_mask};
         3'd2: return {27'b0, m_mode};
         3'd3: return m_cnt;
         3'd4: return m_cmp;
         3'd5: return {30'b0, m_per, m_en};
         default: return 32'd0;
      endcase
   endfunction

   // ---------------- driver / checker ----------------
   task automatic step(input logic r, input logic [4:0] irq, input logic w,
                       input logic [2:0] a, input logic [31:0] d);
      @(negedge clk);
      rst = r; irq_src = irq; bus.we = w; bus.addr = a; bus.data_in = d;
      @(posedge clk);
      model_step(r, irq, w, a, d);
      #1;
   endtask

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s actual=%h expected=%h", name, act, exp);
      end
   endtask

   typedef struct {
      logic        rst;
      logic [4:0]  irq;
      logic        we;
      logic [2:0]  addr;
      logic [31:0] din;
      logic [5:0]  exp_int;
      logic [31:0] exp_rd;
   } vec_t;

   vec_t vec_q[$];

   task automatic add(input logic r, input logic [4:0] irq, input logic w, input logic [2:0] a,
                      input logic [31:0] d, input logic [5:0] ei, input logic [31:0] er);
      vec_t v;
      v.rst = r; v.irq = irq; v.we = w; v.addr = a; v.din = d; v.exp_int = ei; v.exp_rd = er;
      vec_q.push_back(v);
   endtask

   initial begin
      bus.we = 1'b0; bus.addr = '0; bus.data_in = '0;
      model_reset();

      // Reset held with all sources high, then level-mode latency of 3 edges.
      add(1, 5'h1F, 0, 0, 0, 6'h00, 32'h00);
      add(1, 5'h1F, 0, 1, 0, 6'h00, 32'h3F);
      add(0, 5'h1F, 0, 0, 0, 6'h00, 32'h00);
      add(0, 5'h1F, 0, 0, 0, 6'h00, 32'h00);
      add(0, 5'h1F, 0, 0, 0, 6'h1F, 32'h1F);
      // Edge mode, one-cycle pulse on source 2, W1C, then held high.
      add(0, 5'h00, 1, 2, 32'h1F, 6'h1F, 32'h1F);
      add(0, 5'h00, 1, 0, 32'h1F, 6'h00, 32'h00);
      add(0, 5'h04, 0, 0, 0, 6'h00, 32'h00);
      add(0, 5'h00, 0, 0, 0, 6'h00, 32'h00);
      add(0, 5'h00, 0, 0, 0, 6'h04, 32'h04);
      add(0, 5'h04, 0, 0, 0, 6'h04, 32'h04);
      add(0, 5'h04, 0, 0, 0, 6'h04, 32'h04);
      add(0, 5'h04, 0, 0, 0, 6'h04, 32'h04);
      add(0, 5'h04, 1, 0, 32'h04, 6'h00, 32'h00);
      add(0, 5'h04, 0, 0, 0, 6'h00, 32'h00);
      add(0, 5'h04, 0, 0, 0, 6'h00, 32'h00);
      // Back to level mode; set wins over clear while source 0 stays high.
      add(0, 5'h04, 1, 2, 32'h00, 6'h00, 32'h00);
      add(0, 5'h05, 0, 0, 0, 6'h04, 32'h04);
      add(0, 5'h05, 0, 0, 0, 6'h04, 32'h04);
      add(0, 5'h05, 0, 0, 0, 6'h05, 32'h05);
      add(0, 5'h05, 1, 0, 32'h01, 6'h05, 32'h05);
      add(0, 5'h04, 0, 0, 0, 6'h05, 32'h05);
      add(0, 5'h04, 0, 0, 0, 6'h05, 32'h05);
      add(0, 5'h04, 0, 0, 0, 6'h05, 32'h05);
      add(0, 5'h04, 1, 0, 32'h01, 6'h04, 32'h04);
      add(0, 5'h00, 0, 0, 0, 6'h04, 32'h04);
      add(0, 5'h00, 0, 0, 0, 6'h04, 32'h04);
      add(0, 5'h00, 1, 0, 32'h04, 6'h00, 32'h00);
      // Masking keeps the pending bit; unmasking shows it right after the write.
      add(0, 5'h00, 1, 1, 32'h00, 6'h00, 32'h00);
      add(0, 5'h08, 0, 0, 0, 6'h00, 32'h00);
      add(0, 5'h08, 0, 0, 0, 6'h00, 32'h00);
      add(0, 5'h08, 0, 0, 0, 6'h00, 32'h08);
      add(0, 5'h08, 1, 1, 32'h08, 6'h08, 32'h08);
      add(0, 5'h00, 1, 1, 32'h3F, 6'h08, 32'h3F);
      add(0, 5'h00, 0, 0, 0, 6'h08, 32'h08);
      add(0, 5'h00, 1, 0, 32'h08, 6'h00, 32'h00);
      // Periodic timer, CMP=4: CNT 1,2,3,4 then match -> 0 with PEND[5].
      add(0, 5'h00, 1, 4, 32'h4, 6'h00, 32'h4);
      add(0, 5'h00, 1, 5, 32'h3, 6'h00, 32'h3);
      add(0, 5'h00, 0, 3, 0, 6'h00, 32'h1);
      add(0, 5'h00, 0, 3, 0, 6'h00, 32'h2);
      add(0, 5'h00, 0, 3, 0, 6'h00, 32'h3);
      add(0, 5'h00, 0, 3, 0, 6'h00, 32'h4);
      add(0, 5'h00, 0, 3, 0, 6'h20, 32'h0);
      add(0, 5'h00, 0, 3, 0, 6'h20, 32'h1);
      add(0, 5'h00, 0, 3, 0, 6'h20, 32'h2);
      add(0, 5'h00, 0, 3, 0, 6'h20, 32'h3);
      add(0, 5'h00, 0, 3, 0, 6'h20, 32'h4);
      add(0, 5'h00, 0, 3, 0, 6'h20, 32'h0);
      add(0, 5'h00, 1, 4, 32'h4, 6'h00, 32'h4);
      add(0, 5'h00, 0, 3, 0, 6'h00, 32'h2);
      add(0, 5'h00, 0, 3, 0, 6'h00, 32'h3);
      add(0, 5'h00, 0, 3, 0, 6'h00, 32'h4);
      add(0, 5'h00, 0, 3, 0, 6'h20, 32'h0);
      add(0, 5'h00, 0, 3, 0, 6'h20, 32'h1);
      add(0, 5'h00, 0, 3, 0, 6'h20, 32'h2);
      add(0, 5'h00, 0, 3, 0, 6'h20, 32'h3);
      add(0, 5'h00, 0, 3, 0, 6'h20, 32'h4);
      add(0, 5'h00, 1, 4, 32'h4, 6'h20, 32'h4);     // CMP write on a match edge
      // One-shot: single set, then EN reads 0 and CNT stays 0.
      add(0, 5'h00, 1, 5, 32'h1, 6'h20, 32'h1);
      add(0, 5'h00, 1, 0, 32'h20, 6'h00, 32'h0);
      add(0, 5'h00, 0, 3, 0, 6'h00, 32'h3);
      add(0, 5'h00, 0, 3, 0, 6'h00, 32'h4);
      add(0, 5'h00, 0, 3, 0, 6'h20, 32'h0);
      add(0, 5'h00, 0, 5, 0, 6'h20, 32'h0);
      add(0, 5'h00, 0, 3, 0, 6'h20, 32'h0);
      add(0, 5'h00, 0, 3, 0, 6'h20, 32'h0);
      // 32-bit wrap then match at CMP=1.
      add(0, 5'h00, 1, 0, 32'h20, 6'h00, 32'h0);
      add(0, 5'h00, 1, 4, 32'h1, 6'h00, 32'h1);
      add(0, 5'h00, 1, 3, 32'hFFFF_FFFE, 6'h00, 32'hFFFF_FFFE);
      add(0, 5'h00, 1, 5, 32'h1, 6'h00, 32'h1);
      add(0, 5'h00, 0, 3, 0, 6'h00, 32'hFFFF_FFFF);
      add(0, 5'h00, 0, 3, 0, 6'h00, 32'h0);
      add(0, 5'h00, 0, 3, 0, 6'h00, 32'h1);
      add(0, 5'h00, 0, 3, 0, 6'h20, 32'h0);
      add(0, 5'h00, 0, 3, 0, 6'h20, 32'h0);
      // Unmapped indices, then reset mid-count with sources high.
      add(0, 5'h00, 1, 6, 32'hFFFF_FFFF, 6'h20, 32'h0);
      add(0, 5'h00, 0, 7, 0, 6'h20, 32'h0);
      add(0, 5'h00, 1, 5, 32'h3, 6'h20, 32'h3);
      add(0, 5'h00, 0, 3, 0, 6'h20, 32'h1);
      add(1, 5'h1F, 0, 3, 0, 6'h00, 32'h0);
      add(0, 5'h00, 0, 4, 0, 6'h00, 32'hFFFF_FFFF);
      add(0, 5'h00, 0, 5, 0, 6'h00, 32'h0);

      for (int i = 0; i < vec_q.size(); i++) begin
         step(vec_q[i].rst, vec_q[i].irq, vec_q[i].we, vec_q[i].addr, vec_q[i].din);
         check($sformatf("row%0d_int", i), {26'b0, int_}, {26'b0, vec_q[i].exp_int});
         check($sformatf("row%0d_rd", i), bus.data_out, vec_q[i].exp_rd);
      end

      // Random traffic against the reference model.
      step(1, '0, 0, 0, 0);
      begin
         logic [4:0]  irq = '0;
         logic        r, w;
         logic [2:0]  a;
         logic [31:0] d;
         for (int c = 0; c < 3000; c++) begin
            if ($urandom_range(0, 5) == 0) irq = irq ^ 5'($urandom);
            r = ($urandom_range(0, 399) == 0);
            w = ($urandom_range(0, 3) == 0);
            a = 3'($urandom_range(0, 7));
            d = $urandom;
            if (a == 3'd3 || a == 3'd4) begin
               if ($urandom_range(0, 7) == 0) d = 32'hFFFF_FFF0 + 32'($urandom_range(0, 15));
               else                           d = 32'($urandom_range(0, 12));
            end
            if (a == 3'd5 && $urandom_range(0, 2) != 0) d[0] = 1'b1;
            step(r, irq, w, a, d);
            check($sformatf("rnd%0d_int", c), {26'b0, int_}, {26'b0, m_pend & m_mask});
            check($sformatf("rnd%0d_cnt", c), timer_cnt, m_cnt);
            check($sformatf("rnd%0d_rd", c), bus.data_out, model_read(a));
         end
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
